// File: rtl/vx_warp_barrier_ctrl_pkg.sv
// Shared types and helpers for the per-core warp barrier controller.
// Optional watchdog is enabled by defining VX_BARRIER_TIMEOUT_EN.
package vx_warp_barrier_ctrl_pkg;

    typedef enum logic [1:0] {
        BAR_FREE    = 2'd0,
        BAR_GATHER  = 2'd1,
        BAR_RELEASE = 2'd2
    } barrier_state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide enough for any supported warp/barrier count.
    localparam int REQ_FIELD_W = 8;

    typedef struct packed {
        logic [REQ_FIELD_W-1:0] wid;
        logic [REQ_FIELD_W-1:0] bar_id;
        logic [REQ_FIELD_W-1:0] size_m1;
        logic                   is_noop;
    } barrier_req_t;

endpackage

// File: rtl/vx_warp_barrier_ctrl_slot.sv
// One barrier slot: FSM, arrival counter and waiting-warp mask.
// Release/dup indications are combinational on the arrival this cycle.
module vx_barrier_slot
    import vx_warp_barrier_ctrl_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int NW_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 arrive,
    input  logic [NW_WIDTH-1:0]  wid,
    input  logic [NW_WIDTH-1:0]  size_m1,
    output barrier_state_e       state_o,
    output logic [NUM_WARPS-1:0] mask_o,
    output logic                 release_req,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic                 dup_o
);

    barrier_state_e       state_q, state_d;
    logic [NW_WIDTH-1:0]  ctr_q, ctr_d;
    logic [NW_WIDTH-1:0]  size_q, size_d;
    logic [NUM_WARPS-1:0] mask_q, mask_d;
    logic [NUM_WARPS-1:0] wid_oh;

    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        size_d       = size_q;
        mask_d       = mask_q;
        release_req  = 1'b0;
        release_mask = '0;
        dup_o        = 1'b0;
        wid_oh       = NUM_WARPS'(1) << wid;
        if (flush) begin
            state_d = BAR_FREE;
            ctr_d   = '0;
            mask_d  = '0;
        end else begin
            unique case (state_q)
                BAR_FREE: begin
                    if (arrive && size_m1 == '0) begin
                        release_req  = 1'b1;
                        release_mask = wid_oh;
                    end else if (arrive) begin
                        state_d = BAR_GATHER;
                        size_d  = size_m1;
                        ctr_d   = NW_WIDTH'(1);
                        mask_d  = wid_oh;
                    end
                end
                BAR_GATHER: begin
                    if (arrive && (mask_q & wid_oh) != '0) begin
                        dup_o = 1'b1;
                    end else if (arrive && ctr_q == size_q) begin
                        state_d      = BAR_RELEASE;
                        release_req  = 1'b1;
                        release_mask = mask_q | wid_oh;
                        ctr_d        = '0;
                        mask_d       = '0;
                    end else if (arrive) begin
                        ctr_d  = ctr_q + NW_WIDTH'(1);
                        mask_d = mask_q | wid_oh;
                    end
                end
                BAR_RELEASE: state_d = BAR_FREE;
                default:     state_d = BAR_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BAR_FREE;
            ctr_q   <= '0;
            size_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            size_q  <= size_d;
            mask_q  <= mask_d;
        end
    end

    assign state_o = state_q;
    assign mask_o  = mask_q;

endmodule

// File: rtl/vx_warp_barrier_ctrl.sv
// Per-core warp barrier controller; releases gathered warps one cycle after fire.
// Define VX_BARRIER_TIMEOUT_EN to add the stuck-barrier watchdog.
module vx_warp_barrier_ctrl
    import vx_warp_barrier_ctrl_pkg::*;
#(
    parameter int NUM_WARPS      = 4,
    parameter int NUM_BARRIERS   = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int NW_WIDTH      = clog2_min1(NUM_WARPS),
    localparam int NB_WIDTH      = clog2_min1(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_WIDTH-1:0]  req_wid,
    input  logic [NB_WIDTH-1:0]  req_bar_id,
    input  logic [NW_WIDTH-1:0]  req_size_m1,
    input  logic                 req_is_noop,
    input  logic                 flush,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic [NUM_WARPS-1:0] waiting_mask,
    output logic                 err_dup,
    output logic                 busy,
    output logic                 timeout
);

    barrier_state_e       slot_state    [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] slot_mask     [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] slot_rel_mask [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] slot_arrive;
    logic [NUM_BARRIERS-1:0] slot_rel;
    logic [NUM_BARRIERS-1:0] slot_dup;

    logic                 flush_eff;
    logic                 fire;
    logic                 bar_ok;
    logic                 bar_releasing;
    logic                 release_valid_q, release_valid_d;
    logic [NUM_WARPS-1:0] release_mask_q, release_mask_d;
    logic                 err_dup_q, err_dup_d;

    assign bar_ok = int'(req_bar_id) < NUM_BARRIERS;

    always_comb begin
        bar_releasing = 1'b0;
        waiting_mask  = '0;
        busy          = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (req_bar_id == NB_WIDTH'(b)
                && slot_state[b] == BAR_RELEASE)
                bar_releasing = 1'b1;
            waiting_mask = waiting_mask | slot_mask[b];
            if (slot_state[b] != BAR_FREE)
                busy = 1'b1;
        end
    end

    assign req_ready = ~reset & bar_ok
                     & ~bar_releasing & ~flush_eff;
    assign fire = req_valid & req_ready;

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
        assign slot_arrive[b] = fire & ~req_is_noop
                              & (req_bar_id == NB_WIDTH'(b));
        vx_barrier_slot #(
            .NUM_WARPS (NUM_WARPS),
            .NW_WIDTH  (NW_WIDTH)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .flush        (flush_eff),
            .arrive       (slot_arrive[b]),
            .wid          (req_wid),
            .size_m1      (req_size_m1),
            .state_o      (slot_state[b]),
            .mask_o       (slot_mask[b]),
            .release_req  (slot_rel[b]),
            .release_mask (slot_rel_mask[b]),
            .dup_o        (slot_dup[b])
        );
    end

    // Only one request fires per cycle, so at most one source is live.
    always_comb begin
        release_valid_d = 1'b0;
        release_mask_d  = '0;
        err_dup_d       = |slot_dup;
        if (flush_eff) begin
            release_valid_d = 1'b1;
            release_mask_d  = waiting_mask;
        end else if (fire && req_is_noop) begin
            release_valid_d = 1'b1;
            release_mask_d  = NUM_WARPS'(1) << req_wid;
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                if (slot_rel[b]) begin
                    release_valid_d = 1'b1;
                    release_mask_d  = release_mask_d
                                    | slot_rel_mask[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            release_valid_q <= 1'b0;
            release_mask_q  <= '0;
            err_dup_q       <= 1'b0;
        end else begin
            release_valid_q <= release_valid_d;
            release_mask_q  <= release_mask_d;
            err_dup_q       <= err_dup_d;
        end
    end

    assign release_valid = release_valid_q;
    assign release_mask  = release_mask_q;
    assign err_dup       = err_dup_q;

`ifdef VX_BARRIER_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;
    logic        any_gather;

    always_comb begin
        any_gather = 1'b0;
        for (int b = 0; b < NUM_BARRIERS; b++)
            if (slot_state[b] == BAR_GATHER)
                any_gather = 1'b1;
    end

    // Any forward progress restarts the watchdog window.
    always_comb begin
        to_cnt_d  = '0;
        timeout_d = 1'b0;
        if (any_gather && !fire
            && !release_valid_q && !timeout_q) begin
            if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1))
                timeout_d = 1'b1;
            else
                to_cnt_d = to_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout   = timeout_q;
    assign flush_eff = flush | timeout_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset)
            assert (!timeout_q)
            else $warning("barrier timeout, waiting_mask=%b",
                          waiting_mask);
    end
`endif
`else
    assign timeout   = 1'b0;
    assign flush_eff = flush;
`endif

endmodule

// File: tb/tb_vx_warp_barrier_ctrl.sv
// Self-checking bench: set-based barrier model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vx_warp_barrier_ctrl;

    localparam int NW = 4;
    localparam int NB = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_wid;
    logic [0:0] req_bar_id;
    logic [1:0] req_size_m1;
    logic       req_is_noop;
    logic       flush;
    logic       release_valid;
    logic [3:0] release_mask;
    logic [3:0] waiting_mask;
    logic       err_dup;
    logic       busy;
    logic       timeout;

    vx_warp_barrier_ctrl #(
        .NUM_WARPS      (NW),
        .NUM_BARRIERS   (NB),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wid       (req_wid),
        .req_bar_id    (req_bar_id),
        .req_size_m1   (req_size_m1),
        .req_is_noop   (req_is_noop),
        .flush         (flush),
        .release_valid (release_valid),
        .release_mask  (release_mask),
        .waiting_mask  (waiting_mask),
        .err_dup       (err_dup),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Model: each barrier is an open/closed set of warps plus target size.
    bit       m_open [NB];
    bit [3:0] m_set  [NB];
    int       m_size [NB];
    bit       m_cool [NB];
    bit       e_rv;
    bit [3:0] e_rm;
    bit       e_dup;
    bit       run = 1'b0;

    always @(posedge clk) begin : model
        bit [3:0] oh;
        bit [3:0] all;
        bit       fire;
        int       b;
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                m_open[i] = 0;
                m_set[i]  = '0;
                m_size[i] = 0;
                m_cool[i] = 0;
            end
            e_rv  = 0;
            e_rm  = '0;
            e_dup = 0;
        end else begin
            b    = int'(req_bar_id);
            oh   = 4'b0001 << req_wid;
            all  = m_set[0] | m_set[1];
            fire = req_valid && !flush && !m_cool[b];
            e_rv  = 0;
            e_rm  = '0;
            e_dup = 0;
            for (int i = 0; i < NB; i++) m_cool[i] = 0;
            if (flush) begin
                e_rv = 1;
                e_rm = all;
                for (int i = 0; i < NB; i++) begin
                    m_open[i] = 0;
                    m_set[i]  = '0;
                end
            end else if (fire) begin
                if (req_is_noop) begin
                    e_rv = 1;
                    e_rm = oh;
                end else if (!m_open[b]) begin
                    if (req_size_m1 == 2'd0) begin
                        e_rv = 1;
                        e_rm = oh;
                    end else begin
                        m_open[b] = 1;
                        m_set[b]  = oh;
                        m_size[b] = int'(req_size_m1);
                    end
                end else if ((m_set[b] & oh) != 0) begin
                    e_dup = 1;
                end else if ($countones(m_set[b]) == m_size[b]) begin
                    e_rv      = 1;
                    e_rm      = m_set[b] | oh;
                    m_open[b] = 0;
                    m_set[b]  = '0;
                    m_cool[b] = 1;
                end else begin
                    m_set[b] = m_set[b] | oh;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("release_valid", release_valid, e_rv);
            if (e_rv)
                check("release_mask", release_mask, e_rm);
            check("err_dup", err_dup, e_dup);
            check("waiting_mask", waiting_mask,
                  m_set[0] | m_set[1]);
            check("busy", busy,
                  m_open[0] | m_open[1] | m_cool[0] | m_cool[1]);
            check("req_ready", req_ready,
                  !reset && !flush && !m_cool[int'(req_bar_id)]);
            check("timeout", timeout, 0);
        end
    end

    task automatic send(input int w, input int b,
                        input int s, input bit noop);
        req_valid   = 1'b1;
        req_wid     = 2'(w);
        req_bar_id  = 1'(b);
        req_size_m1 = 2'(s);
        req_is_noop = noop;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_is_noop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_wid     = '0;
        req_bar_id  = '0;
        req_size_m1 = '0;
        req_is_noop = 1'b0;
        flush       = 1'b0;
        @(posedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_valid", release_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_waiting", waiting_mask, 0);
        check("rst_ready", req_ready, 0);
        reset = 1'b0;
        idle(1);

        // Four warps gather on bar 0.
        send(0, 0, 3, 0);
        check("g4_w0_rv", release_valid, 0);
        send(1, 0, 3, 0);
        send(2, 0, 3, 0);
        check("g4_w2_rv", release_valid, 0);
        check("g4_wait", waiting_mask, 4'b0111);
        send(3, 0, 3, 0);
        check("g4_rv", release_valid, 1);
        check("g4_rm", release_mask, 4'b1111);
        check("g4_busy_rel", busy, 1);
        idle(1);
        check("g4_busy_free", busy, 0);

        // Noop releases only itself.
        send(2, 1, 0, 1);
        check("noop_rv", release_valid, 1);
        check("noop_rm", release_mask, 4'b0100);
        check("noop_busy", busy, 0);

        // Duplicate arrival.
        send(1, 0, 2, 0);
        send(1, 0, 2, 0);
        check("dup_pulse", err_dup, 1);
        check("dup_wait", waiting_mask, 4'b0010);
        send(0, 0, 2, 0);
        check("dup_nodup", err_dup, 0);
        check("dup_rv0", release_valid, 0);
        send(3, 0, 2, 0);
        check("dup_rm", release_mask, 4'b1011);
        idle(1);

        // Bar 0 in RELEASE blocks bar 0 only.
        send(2, 0, 1, 0);
        send(0, 0, 1, 0);
        check("rel_rm", release_mask, 4'b0101);
        req_valid   = 1'b1;
        req_wid     = 2'd3;
        req_bar_id  = 1'b0;
        req_size_m1 = 2'd0;
        #1;
        check("rel_ready_b0", req_ready, 0);
        req_wid     = 2'd1;
        req_bar_id  = 1'b1;
        req_size_m1 = 2'd1;
        #1;
        check("rel_ready_b1", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rel_b1_wait", waiting_mask, 4'b0010);
        send(3, 1, 1, 0);
        check("rel_b1_rm", release_mask, 4'b1010);
        idle(1);

        // Flush with a same-cycle request.
        send(0, 0, 3, 0);
        send(2, 1, 3, 0);
        flush       = 1'b1;
        req_valid   = 1'b1;
        req_wid     = 2'd3;
        req_bar_id  = 1'b0;
        req_is_noop = 1'b1;
        #1;
        check("fl_ready", req_ready, 0);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        req_valid   = 1'b0;
        req_is_noop = 1'b0;
        check("fl_rv", release_valid, 1);
        check("fl_rm", release_mask, 4'b0101);
        check("fl_busy", busy, 0);
        check("fl_wait", waiting_mask, 0);

        // size_m1 = 0 on a free slot self-releases.
        send(3, 1, 0, 0);
        check("self_rm", release_mask, 4'b1000);
        check("self_busy", busy, 0);

        // Later arrival's size is ignored.
        send(0, 1, 1, 0);
        send(1, 1, 3, 0);
        check("size_rv", release_valid, 1);
        check("size_rm", release_mask, 4'b0011);
        idle(1);

        // Reset mid-gather discards state silently.
        send(1, 0, 3, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rmid_rv", release_valid, 0);
        check("rmid_wait", waiting_mask, 0);
        check("rmid_busy", busy, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
